// File: rtl/hit_pkg.sv
// Shared types and widths for the player hit manager.
// FSM states and counter widths.
package hit_pkg;

  typedef enum logic [1:0] {
    PLAY,
    HIT,
    OVER
  } hit_state_t;

  localparam int LIVES_W = 3;
  localparam int INV_W   = 8;

endpackage

// File: rtl/frame_down_counter.sv
// Frame-based down counter for the invulnerability window.
// Load has priority over decrement; never wraps below zero.
module frame_down_counter
  import hit_pkg::*;
#(
  parameter int W = INV_W
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         blink,
  output logic         is_zero,
  output logic         is_one
);

  logic [W-1:0] cnt;

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == W'(1));
  assign blink   = cnt[2];

  // Load a new window or count one frame down.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !is_zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/player_hit_manager.sv
// Turns collision hits and rope grabs into lives, score,
// invulnerability timing and game-over.
module player_hit_manager
  import hit_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int ROPE_POINTS   = 10,
  parameter int SCORE_W       = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               SingleHitPulse,
  input  logic               ropeCollision,
  input  logic               restart_req,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               invulnerable,
  output logic               flash,
  output logic               game_over,
  output logic               lose_life_pulse
);

  localparam logic [LIVES_W-1:0] LIVES_RST =
    LIVES_W'(LIVES_INIT);
  localparam logic [INV_W-1:0] INV_LOAD =
    INV_W'(INVULN_FRAMES);
  localparam logic [SCORE_W:0] ROPE_INC =
    (SCORE_W+1)'(ROPE_POINTS);

  hit_state_t state;

  logic rope_seen;
  logic rope_prev;
  logic inv_load;
  logic inv_dec;
  logic inv_blink;
  logic inv_zero;
  logic inv_one;
  logic restart;
  logic grab;
  logic [SCORE_W:0] score_sum;

  assign restart  = (state == OVER) && restart_req;
  assign inv_load = (state == PLAY) && SingleHitPulse
                    && (lives > LIVES_W'(1));
  assign inv_dec  = (state == HIT) && startOfFrame;
  assign grab     = startOfFrame && rope_seen && !rope_prev
                    && (state != OVER);
  assign score_sum = {1'b0, score} + ROPE_INC;
  assign flash    = invulnerable && inv_blink && !inv_zero;

  frame_down_counter #(
    .W(INV_W)
  ) u_inv_cnt (
    .clk     (clk),
    .resetN  (resetN),
    .load    (inv_load),
    .load_val(INV_LOAD),
    .dec     (inv_dec),
    .blink   (inv_blink),
    .is_zero (inv_zero),
    .is_one  (inv_one)
  );

  // Game FSM with lives and its registered status outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= PLAY;
      lives           <= LIVES_RST;
      invulnerable    <= 1'b0;
      game_over       <= 1'b0;
      lose_life_pulse <= 1'b0;
    end else begin
      lose_life_pulse <= 1'b0;
      unique case (state)
        PLAY: begin
          if (SingleHitPulse && lives != '0) begin
            lives           <= lives - LIVES_W'(1);
            lose_life_pulse <= 1'b1;
            if (lives == LIVES_W'(1)) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state        <= HIT;
              invulnerable <= 1'b1;
            end
          end
        end
        HIT: begin
          if (startOfFrame && (inv_one || inv_zero)) begin
            state        <= PLAY;
            invulnerable <= 1'b0;
          end
        end
        OVER: begin
          if (restart_req) begin
            state     <= PLAY;
            lives     <= LIVES_RST;
            game_over <= 1'b0;
          end
        end
        default: begin
          state        <= PLAY;
          invulnerable <= 1'b0;
          game_over    <= 1'b0;
        end
      endcase
    end
  end

  // Per-frame rope presence: this frame and the one before.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rope_seen <= 1'b0;
      rope_prev <= 1'b0;
    end else if (restart) begin
      rope_seen <= 1'b0;
      rope_prev <= 1'b0;
    end else if (startOfFrame) begin
      rope_prev <= rope_seen;
      rope_seen <= ropeCollision;
    end else if (ropeCollision) begin
      rope_seen <= 1'b1;
    end
  end

  // Saturating score, bumped once per newly grabbed rope.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score <= '0;
    end else if (restart) begin
      score <= '0;
    end else if (grab) begin
      if (score_sum[SCORE_W]) begin
        score <= '1;
      end else begin
        score <= score_sum[SCORE_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_player_hit_manager.sv
// Randomized + directed scoreboard bench for player_hit_manager.
// Two instances with different parameters share one stimulus.
module tb_player_hit_manager;

  localparam int FLEN = 4;

  localparam int M_PLAY = 0;
  localparam int M_HIT  = 1;
  localparam int M_OVER = 2;

  typedef struct {
    int mode;
    int lives;
    int score;
    int inv_left;
    bit cur;
    bit prv;
    bit lose;
  } ms_t;

  typedef struct {
    int init;
    int frames;
    int pts;
    int maxs;
  } mp_t;

  typedef struct packed {
    int lives;
    int score;
    bit inv;
    bit flash;
    bit go;
    bit lose;
  } exp_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0;
  logic hit = 1'b0;
  logic rope = 1'b0;
  logic rr = 1'b0;

  logic [2:0]  lives_a, lives_b;
  logic [15:0] score_a;
  logic [3:0]  score_b;
  logic inv_a, fl_a, go_a, ll_a;
  logic inv_b, fl_b, go_b, ll_b;

  int n_chk = 0;
  int n_pass = 0;
  int cnum = 0;
  bit keep_rst = 1'b1;

  ms_t ma, mb;
  mp_t pa = '{3, 60, 10, 65535};
  mp_t pb = '{2, 5, 4, 15};
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  player_hit_manager dut_a (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (sof),
    .SingleHitPulse (hit),
    .ropeCollision  (rope),
    .restart_req    (rr),
    .lives          (lives_a),
    .score          (score_a),
    .invulnerable   (inv_a),
    .flash          (fl_a),
    .game_over      (go_a),
    .lose_life_pulse(ll_a)
  );

  player_hit_manager #(
    .LIVES_INIT   (2),
    .INVULN_FRAMES(5),
    .ROPE_POINTS  (4),
    .SCORE_W      (4)
  ) dut_b (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (sof),
    .SingleHitPulse (hit),
    .ropeCollision  (rope),
    .restart_req    (rr),
    .lives          (lives_b),
    .score          (score_b),
    .invulnerable   (inv_b),
    .flash          (fl_b),
    .game_over      (go_b),
    .lose_life_pulse(ll_b)
  );

  function automatic ms_t mreset(mp_t p);
    ms_t s;
    s.mode = M_PLAY;
    s.lives = p.init;
    s.score = 0;
    s.inv_left = 0;
    s.cur = 0;
    s.prv = 0;
    s.lose = 0;
    return s;
  endfunction

  // Game rules, one clock of inputs at a time.
  function automatic ms_t mstep(ms_t s, mp_t p,
                                bit h, bit f, bit rc, bit r);
    ms_t n = s;
    int sum;
    n.lose = 0;
    if (f && s.cur && !s.prv && s.mode != M_OVER) begin
      sum = s.score + p.pts;
      n.score = (sum > p.maxs) ? p.maxs : sum;
    end
    if (f) begin
      n.prv = s.cur;
      n.cur = rc;
    end else if (rc) begin
      n.cur = 1;
    end
    case (s.mode)
      M_PLAY: if (h) begin
        n.lives = s.lives - 1;
        n.lose = 1;
        if (n.lives == 0) n.mode = M_OVER;
        else begin
          n.mode = M_HIT;
          n.inv_left = p.frames;
        end
      end
      M_HIT: if (f) begin
        n.inv_left = s.inv_left - 1;
        if (n.inv_left == 0) n.mode = M_PLAY;
      end
      default: if (r) begin
        n.mode = M_PLAY;
        n.lives = p.init;
        n.score = 0;
        n.cur = 0;
        n.prv = 0;
      end
    endcase
    return n;
  endfunction

  function automatic exp_t mexp(ms_t s);
    exp_t e;
    e.lives = s.lives;
    e.score = s.score;
    e.inv = (s.mode == M_HIT);
    e.flash = (s.mode == M_HIT) && s.inv_left[2];
    e.go = (s.mode == M_OVER);
    e.lose = s.lose;
    return e;
  endfunction

  function automatic exp_t got_a();
    exp_t g;
    g.lives = int'(lives_a);
    g.score = int'(score_a);
    g.inv = inv_a;
    g.flash = fl_a;
    g.go = go_a;
    g.lose = ll_a;
    return g;
  endfunction

  function automatic exp_t got_b();
    exp_t g;
    g.lives = int'(lives_b);
    g.score = int'(score_b);
    g.inv = inv_b;
    g.flash = fl_b;
    g.go = go_b;
    g.lose = ll_b;
    return g;
  endfunction

  task automatic chk(string nm, exp_t g, exp_t e);
    n_chk++;
    if (g == e) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t got lv=%0d sc=%0d inv=%0b fl=%0b go=%0b ll=%0b exp lv=%0d sc=%0d inv=%0b fl=%0b go=%0b ll=%0b",
               nm, $time, g.lives, g.score, g.inv, g.flash,
               g.go, g.lose, e.lives, e.score, e.inv, e.flash,
               e.go, e.lose);
    end
  endtask

  // Monitor: compare each cycle's outputs with the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("dut_a", got_a(), e);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("dut_b", got_b(), e);
      end
    end
  end

  // Drive one clock of inputs and queue the predicted response.
  task automatic cyc(bit h, bit rc, bit r);
    @(negedge clk);
    resetN = !keep_rst;
    sof = (cnum % FLEN == 0);
    hit = h;
    rope = rc;
    rr = r;
    if (keep_rst) begin
      ma = mreset(pa);
      mb = mreset(pb);
    end else begin
      ma = mstep(ma, pa, h, sof, rc, r);
      mb = mstep(mb, pb, h, sof, rc, r);
    end
    qa.push_back(mexp(ma));
    qb.push_back(mexp(mb));
    cnum++;
  endtask

  task automatic run(int n, bit rc);
    for (int i = 0; i < n; i++) cyc(0, rc, 0);
  endtask

  task automatic align();
    while (cnum % FLEN != 0) cyc(0, 0, 0);
  endtask

  // Assert reset between clock edges and check it acts at once.
  task automatic async_reset(string nm);
    @(posedge clk);
    #3;
    keep_rst = 1'b1;
    resetN = 1'b0;
    #1;
    chk({nm, "_a"}, got_a(), mexp(mreset(pa)));
    chk({nm, "_b"}, got_b(), mexp(mreset(pb)));
    run(3, 0);
    keep_rst = 1'b0;
  endtask

  initial begin
    bit used;
    bit frope;
    bit h;
    bit rc;
    bit r;
    ma = mreset(pa);
    mb = mreset(pb);
    run(3, 0);
    chk("reset_a", got_a(), mexp(mreset(pa)));
    chk("reset_b", got_b(), mexp(mreset(pb)));
    keep_rst = 1'b0;

    run(5, 0);
    cyc(0, 0, 1);
    run(3, 0);
    cyc(1, 0, 0);
    run(FLEN * 10, 0);
    cyc(1, 0, 0);
    run(FLEN * 55, 0);
    cyc(1, 0, 0);
    run(FLEN * 62, 0);
    cyc(1, 0, 0);
    run(FLEN * 62, 0);
    cyc(1, 0, 0);
    run(FLEN * 2, 0);
    cyc(1, 1, 0);
    run(FLEN * 2, 1);
    cyc(0, 0, 1);
    run(6, 0);

    align();
    run(FLEN, 1);
    run(FLEN, 1);
    run(FLEN, 1);
    run(FLEN, 0);
    run(FLEN, 1);
    run(FLEN * 2, 0);
    for (int i = 0; i < 5; i++) begin
      run(FLEN, 1);
      run(FLEN, 0);
    end
    run(FLEN, 0);

    cyc(1, 0, 0);
    run(FLEN * 3 + 1, 0);
    async_reset("rst_mid_hit");
    run(8, 0);

    used = 0;
    frope = 0;
    for (int i = 0; i < 4000; i++) begin
      if (cnum % FLEN == 0) begin
        used = 0;
        frope = ($urandom_range(0, 2) != 0);
      end
      h = !used && ($urandom_range(0, 29) == 0);
      if (h) used = 1;
      rc = frope && ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 39) == 0);
      cyc(h, rc, r);
    end
    async_reset("rst_random");
    run(4, 0);
    @(posedge clk);
    #4;
    n_chk++;
    if (qa.size() == 0 && qb.size() == 0) n_pass++;
    else $display("FAIL drain got %0d/%0d pending exp 0",
                  qa.size(), qb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
